fir_mc: RTL and testbench
=========================

// Module: fir_mc
// PURPOSE
//   Parametrised multi-channel FIR filter between audio_codec read and write sides.
//   Replaces the per-channel fir instances with one time-multiplexed MAC serving N_CH
//   channels. Run-time loadable coefficients, bypass mode, sticky overrun flag.
//   One frame (all channels) is accepted per input_ready strobe.
//   One output_ready strobe is issued per processed frame.
// PARAMETERS
//   W     16  sample width, signed two's complement
//   CW    16  coefficient width, signed Q1.(CW-1)
//   TAPS  16  taps per channel (>=2); one shared coefficient set for all channels
//   N_CH  2   channel count (>=1); ch0 = left, ch1 = right
// PORTS
//   ck           in   1            system clock (CLOCK_50)
//   rst          in   1            synchronous reset, active-high
//   in           in   N_CH*W       input frame; channel k at [k*W +: W]
//   input_ready  in   1            1-cycle strobe: frame on `in` is valid
//   bypass       in   1            sampled on accept: 1 = pass frame through unfiltered
//   coef_we      in   1            coefficient write strobe
//   coef_addr    in   $clog2(TAPS) tap index to write
//   coef_data    in   CW           coefficient value
//   clr_overrun  in   1            clears overrun
//   out          out  N_CH*W       filtered frame, same packing as `in`; held between frames
//   output_ready out  1            1-cycle strobe: `out` is valid
//   busy         out  1            1 while not in IDLE
//   overrun      out  1            sticky: a frame was dropped
// BEHAVIOUR
// - Reset (rst=1 at a ck edge):
//   - state=IDLE; out=0; output_ready=0; busy=0; overrun=0.
//   - All delay lines and the accumulator are cleared.
//   - Coefficients reset to impulse: c[0]=2^(CW-1)-1, all other taps 0.
//   - rst mid-operation aborts the frame; no output_ready is issued for it.
// - Delay lines: per channel, TAPS samples x[k][0..TAPS-1].
//   - On accept, every channel shifts: x[k][0] <= new sample, and x[k][i] <= x[k][i-1].
//   - Shifts happen in bypass mode too.
// - FSM states: IDLE, MAC, STORE, DONE.
//   - IDLE: on input_ready, accept the frame and latch bypass.
//     - bypass=0: ch=0, tap=0, acc=0, go to MAC.
//     - bypass=1: out<=in, go to DONE.
//   - MAC: each cycle acc += x[ch][tap]*c[tap] (full-precision signed multiply), then tap++.
//     - After tap==TAPS-1 has been accumulated, go to STORE.
//   - STORE: out[ch] <= sat_W((acc + 2^(CW-2)) >>> (CW-1)); clear acc and tap.
//     - If ch==N_CH-1, go to DONE; otherwise ch++ and return to MAC.
//   - DONE: output_ready=1 for exactly this cycle, then go to IDLE.
// - Arithmetic widths and rounding:
//   - acc width = W+CW+$clog2(TAPS).
//   - Rounding is round-half-up, followed by an arithmetic right shift.
//   - Saturation clamps to [-2^(W-1), 2^(W-1)-1]; the result never wraps.
// - Latency: input_ready sampled in cycle T gives output_ready in cycle T+N_CH*(TAPS+1)+1.
//   - Defaults: 35 cycles (<< 1041 cycles per 48 kHz sample).
//   - Bypass: output_ready in cycle T+1.
// - out changes only in STORE (filtered), or at accept (bypass).
//   - Channels already written may update before output_ready; consumers read on output_ready only.
// - input_ready while busy: the frame is dropped and delay lines are not shifted.
//   - overrun<=1 and the running frame is unaffected.
// - overrun clears on clr_overrun. If clr_overrun and a drop occur in the same cycle, the set wins.
// - coef_we in IDLE: c[coef_addr]<=coef_data.
//   - If it coincides with an accept, the new value is used for that frame.
// - coef_we while busy: ignored; the coefficient set stays constant within a frame.
// TESTING
// 1. After reset, bypass=0, frame ch0=0x1234, ch1=0xFF00 -> output_ready at T+35.
//    Expect out ch0=0x1234, ch1=0xFF00 (impulse passthrough).
// 2. Load c[0..3]=0x2000, c[4..15]=0; five frames with ch0=0x4000.
//    Expect ch0 outputs 0x1000, 0x2000, 0x3000, 0x4000, 0x4000.
// 3. All c=0x7FFF; constant 0x7FFF input -> out saturates at 0x7FFF by the 2nd frame.
//    Constant 0x8000 input -> out saturates at 0x8000; never wraps.
// 4. Second input_ready 10 cycles after the first -> dropped, with only one output_ready.
//    overrun=1 until clr_overrun. The next frame shows the history was not shifted by the dropped one.
// 5. bypass=1, frame ch0=0x0ABC, ch1=0x8001 -> out equals input at T+1, output_ready at T+1.
//    The following filtered frame uses the shifted history.
// 6. rst asserted at T+10 of a frame -> no output_ready; busy=0 and out=0 next cycle.
//    Coefficients are back to impulse, so test 1 passes again.

Source files
------------

// File: rtl/fir_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks every channel's delay line
// against a single run-time loadable coefficient set, with bypass and sticky overrun.
module fir_mc #(
  parameter int W    = 16,
  parameter int CW   = 16,
  parameter int TAPS = 16,
  parameter int N_CH = 2
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic [N_CH*W-1:0]       in,
  input  logic                    input_ready,
  input  logic                    bypass,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_data,
  input  logic                    clr_overrun,
  output logic [N_CH*W-1:0]       out,
  output logic                    output_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int TW  = $clog2(TAPS);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW  = W + CW + TW;

  localparam logic signed [AW-1:0] RND  = AW'(1 << (CW - 2));
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  localparam logic signed [CW-1:0] C0   = {1'b0, {(CW-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  state_t state, state_next;

  logic [TW-1:0]          tap;
  logic [CHW-1:0]         ch;
  logic signed [W-1:0]    x [N_CH][TAPS];
  logic signed [CW-1:0]   c [TAPS];
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   prod;
  logic signed [AW-1:0]   shifted;
  logic signed [W-1:0]    sat;

  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bypass only steers the IDLE exit, so it is consumed at the accepting edge and needs no register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (input_ready) state_next = bypass ? DONE : MAC;
      MAC:     if (tap == TW'(TAPS - 1)) state_next = STORE;
      STORE:   state_next = (ch == CHW'(N_CH - 1)) ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    output_ready = (state == DONE);
    busy         = (state != IDLE);
  end

  always_comb begin
    prod    = AW'(x[ch][tap]) * AW'(c[tap]);
    shifted = (acc + RND) >>> (CW - 1);
    if (shifted > MAXV)      sat = MAXV[W-1:0];
    else if (shifted < MINV) sat = MINV[W-1:0];
    else                     sat = shifted[W-1:0];
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      out     <= '0;
      acc     <= '0;
      tap     <= '0;
      ch      <= '0;
      overrun <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++)
        for (int unsigned i = 0; i < TAPS; i++)
          x[k][i] <= '0;
      for (int unsigned i = 0; i < TAPS; i++)
        c[i] <= (i == 0) ? C0 : '0;
    end else begin
      if (input_ready && state != IDLE) overrun <= 1'b1;
      else if (clr_overrun)             overrun <= 1'b0;

      if (coef_we && state == IDLE) c[coef_addr] <= coef_data;

      case (state)
        IDLE: if (input_ready) begin
          for (int unsigned k = 0; k < N_CH; k++) begin
            x[k][0] <= in[k*W +: W];
            for (int unsigned i = 1; i < TAPS; i++)
              x[k][i] <= x[k][i-1];
          end
          if (bypass) out <= in;
          else begin
            acc <= '0;
            tap <= '0;
            ch  <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod;
          tap <= tap + TW'(1);
        end
        STORE: begin
          out[ch*W +: W] <= sat;
          acc <= '0;
          tap <= '0;
          if (ch != CHW'(N_CH - 1)) ch <= ch + CHW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mc.sv
// Scoreboard bench for fir_mc: stimulus pushes model results, a monitor checks each output_ready.
module tb_fir_mc;

  localparam int W    = 16;
  localparam int CW   = 16;
  localparam int TAPS = 16;
  localparam int N_CH = 2;
  localparam int LAT  = N_CH * (TAPS + 1) + 1;

  logic                    ck = 1'b0;
  logic                    rst = 1'b1;
  logic [N_CH*W-1:0]       frame_in = '0;
  logic                    input_ready = 1'b0;
  logic                    bypass = 1'b0;
  logic                    coef_we = 1'b0;
  logic [$clog2(TAPS)-1:0] coef_addr = '0;
  logic [CW-1:0]           coef_data = '0;
  logic                    clr_overrun = 1'b0;
  logic [N_CH*W-1:0]       frame_out;
  logic                    output_ready;
  logic                    busy;
  logic                    overrun;

  fir_mc #(.W(W), .CW(CW), .TAPS(TAPS), .N_CH(N_CH)) dut (
    .ck(ck), .rst(rst), .in(frame_in), .input_ready(input_ready), .bypass(bypass),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .clr_overrun(clr_overrun), .out(frame_out), .output_ready(output_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 ck = ~ck;

  int unsigned cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain FIR arithmetic on sample histories.
  typedef struct {
    logic [N_CH*W-1:0] d;
    int unsigned       c;
  } exp_t;

  exp_t        sb[$];
  longint      hist[N_CH][TAPS];
  longint      coef[TAPS];
  bit          ovr_m;
  int unsigned busy_until;

  function automatic logic [W-1:0] ref_ch(input int k);
    longint acc, r, mx, mn;
    logic [63:0] rb;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += hist[k][i] * coef[i];
    r  = (acc + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
    mx = (longint'(1) <<< (W - 1)) - 1;
    mn = -(longint'(1) <<< (W - 1));
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    rb = r;
    return rb[W-1:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++)
      for (int i = 0; i < TAPS; i++) hist[k][i] = 0;
    for (int i = 0; i < TAPS; i++) coef[i] = 0;
    coef[0]    = (longint'(1) <<< (CW - 1)) - 1;
    ovr_m      = 1'b0;
    busy_until = cyc;
  endtask

  always @(negedge ck) begin
    if (!rst && output_ready) begin
      if (sb.size() == 0) check("spurious_output_ready", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("out", 64'(frame_out), 64'(e.d));
        check("latency", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge ck);
  endtask

  task automatic send(input logic [N_CH*W-1:0] f, input bit byp, input bit push = 1'b1,
                      input bit we = 1'b0, input int unsigned a = 0,
                      input logic [CW-1:0] d = '0, input bit clr = 1'b0);
    int unsigned e;
    logic [N_CH*W-1:0] r;
    logic signed [W-1:0] s;
    logic signed [CW-1:0] cs;
    exp_t x;
    frame_in    = f;
    bypass      = byp;
    input_ready = 1'b1;
    coef_we     = we;
    coef_addr   = a[$clog2(TAPS)-1:0];
    coef_data   = d;
    clr_overrun = clr;
    e = cyc + 1;
    if (e > busy_until) begin
      if (we) begin cs = d; coef[a] = cs; end
      for (int k = 0; k < N_CH; k++) begin
        for (int i = TAPS - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
        s = f[k*W +: W];
        hist[k][0] = s;
      end
      if (byp) begin
        r = f;
        busy_until = e + 1;
        x.c = e;
      end else begin
        for (int k = 0; k < N_CH; k++) r[k*W +: W] = ref_ch(k);
        busy_until = e + LAT;
        x.c = e + LAT - 1;
      end
      x.d = r;
      if (push) sb.push_back(x);
      if (clr) ovr_m = 1'b0;
    end else begin
      ovr_m = 1'b1;
    end
    tick();
    input_ready = 1'b0;
    bypass      = 1'b0;
    coef_we     = 1'b0;
    clr_overrun = 1'b0;
    check("overrun", 64'(overrun), 64'(ovr_m));
  endtask

  task automatic wcoef(input int unsigned a, input logic [CW-1:0] d);
    logic signed [CW-1:0] cs;
    coef_we   = 1'b1;
    coef_addr = a[$clog2(TAPS)-1:0];
    coef_data = d;
    if (cyc + 1 > busy_until) begin cs = d; coef[a] = cs; end
    tick();
    coef_we = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < busy_until) tick();
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    rst = 1'b0;
    model_reset();
    check("rst_out", 64'(frame_out), 64'd0);
    check("rst_output_ready", 64'(output_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // Impulse coefficients pass the frame through.
    send(32'hFF00_1234, 1'b0);
    wait_idle();

    // Four-tap moving sum ramps up then settles.
    do_reset();
    for (int i = 0; i < TAPS; i++) wcoef(i, (i < 4) ? 16'h2000 : 16'h0000);
    for (int i = 0; i < 5; i++) begin
      send({16'($urandom), 16'h4000}, 1'b0);
      wait_idle();
    end

    // Saturation at both rails.
    do_reset();
    for (int i = 0; i < TAPS; i++) wcoef(i, 16'h7FFF);
    for (int i = 0; i < 3; i++) begin send(32'h7FFF_7FFF, 1'b0); wait_idle(); end
    for (int i = 0; i < 3; i++) begin send(32'h8000_8000, 1'b0); wait_idle(); end

    // Drop while busy, ignored coef write, set-over-clear, then history check.
    do_reset();
    wcoef(1, 16'h4000);
    send(32'h1111_2222, 1'b0);
    tick(9);
    check("busy_running", 64'(busy), 64'd1);
    send(32'h7777_7777, 1'b0);
    wcoef(2, 16'h7FFF);
    send(32'h5555_5555, 1'b0, 1'b1, 1'b0, 0, '0, 1'b1);
    wait_idle();
    check("overrun_held", 64'(overrun), 64'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    ovr_m = 1'b0;
    check("overrun_clr", 64'(overrun), 64'd0);
    send(32'h0100_0300, 1'b0);
    wait_idle();

    // Bypass, then a filtered frame with a coefficient written on the accepting edge.
    do_reset();
    wcoef(0, 16'h2000);
    send(32'h8001_0ABC, 1'b1);
    wait_idle();
    send(32'h0400_F000, 1'b0, 1'b1, 1'b1, 1, 16'h6000);
    wait_idle();

    // Reset mid-frame aborts with no output_ready.
    send(32'h1234_5678, 1'b0, 1'b0);
    tick(9);
    do_reset();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out", 64'(frame_out), 64'd0);
    check("abort_output_ready", 64'(output_ready), 64'd0);
    send(32'hFF00_1234, 1'b0);
    wait_idle();

    // Randomised traffic with random gaps, bypass, coefficient writes and clears.
    do_reset();
    for (int i = 0; i < TAPS; i++) wcoef(i, 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      tick($urandom_range(0, 40));
      send(32'($urandom), ($urandom_range(0, 3) == 0), 1'b1,
           ($urandom_range(0, 4) == 0), $urandom_range(0, TAPS - 1), 16'($urandom),
           ($urandom_range(0, 2) == 0));
    end
    wait_idle();
    tick(3);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
